// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the MIPS inter-stage pipeline registers.
// Provides the NOP encoding, the $zero register number, default widths
// and a helper for locating a lane inside a packed multi-lane bus.
package pipe_pkg;

   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_ADDR_W   = 5;
   localparam int unsigned DEF_NUM_OPND = 2;
   localparam int unsigned IR_W         = 32;

   // Register number of $zero; a write to it never carries a real value.
   localparam int unsigned REG_ZERO = 0;

   // All-zero instruction word decodes as sll $0,$0,0, i.e. a NOP.
   localparam logic [IR_W-1:0] NOP_IR = 32'h0000_0000;

   // Low bit index of lane 'lane' in a bus built from 'width'-bit lanes.
   function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_opnd_hold_slot.sv
// One operand lane of a pipeline register: the operand value and the
// register number it was read from.  While the stage is held, the value
// is refreshed from the snoop bus whenever that bus writes the lane's
// source register, so results forwarded during a long stall are kept.
module opnd_hold_slot
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W        = DEF_DATA_W,
   parameter int unsigned ADDR_W        = DEF_ADDR_W,
   parameter int unsigned SNOOP_ON_HOLD = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              hold_valid,
   input  logic              snp_we,
   input  logic [ADDR_W-1:0] snp_addr,
   input  logic [DATA_W-1:0] snp_data,
   input  logic [DATA_W-1:0] opnd_in,
   input  logic [ADDR_W-1:0] src_in,
   output logic [DATA_W-1:0] opnd_out,
   output logic [ADDR_W-1:0] src_out
);

   logic [DATA_W-1:0] opnd_q, opnd_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic              snoop_hit;

   // Next lane contents: flush clears, hold keeps (or snoops), otherwise load.
   always_comb begin
      opnd_d    = opnd_q;
      src_d     = src_q;
      snoop_hit = (SNOOP_ON_HOLD != 0) && hold_valid && snp_we &&
                  (snp_addr != ADDR_W'(REG_ZERO)) && (snp_addr == src_q);
      if (flush) begin
         opnd_d = '0;
         src_d  = '0;
      end else if (stall) begin
         if (snoop_hit) begin
            opnd_d = snp_data;
         end
      end else begin
         opnd_d = opnd_in;
         src_d  = src_in;
      end
   end

   // Lane state register; reset empties the lane immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         opnd_q <= '0;
         src_q  <= '0;
      end else begin
         opnd_q <= opnd_d;
         src_q  <= src_d;
      end
   end

   assign opnd_out = opnd_q;
   assign src_out  = src_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register for the 5-stage MIPS core (D/E, E/M,
// M/W).  Carries IR, PC+4, immediate, NUM_OPND operand lanes and the
// write-back tag, plus a valid bit.  flush inserts a bubble and beats
// stall; stall holds everything except operand lanes, which snoop the
// forwarding bus.
// Optional performance counters: define PIPE_STAGE_PERF_CNT_EN to build
// stall_cnt / bubble_cnt; otherwise both outputs read 0.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W        = DEF_DATA_W,
   parameter int unsigned NUM_OPND      = DEF_NUM_OPND,
   parameter int unsigned ADDR_W        = DEF_ADDR_W,
   parameter int unsigned SNOOP_ON_HOLD = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       valid_in,
   input  logic [IR_W-1:0]            ir_in,
   input  logic [DATA_W-1:0]          pc4_in,
   input  logic [DATA_W-1:0]          ext_in,
   input  logic [NUM_OPND*DATA_W-1:0] opnd_in,
   input  logic [NUM_OPND*ADDR_W-1:0] opnd_src_in,
   input  logic [ADDR_W-1:0]          fwd_addr_in,
   input  logic [DATA_W-1:0]          fwd_data_in,
   input  logic                       fwd_rdy_in,
   input  logic                       snp_we,
   input  logic [ADDR_W-1:0]          snp_addr,
   input  logic [DATA_W-1:0]          snp_data,
   output logic                       valid_out,
   output logic [IR_W-1:0]            ir_out,
   output logic [DATA_W-1:0]          pc4_out,
   output logic [DATA_W-1:0]          ext_out,
   output logic [NUM_OPND*DATA_W-1:0] opnd_out,
   output logic [NUM_OPND*ADDR_W-1:0] opnd_src_out,
   output logic [ADDR_W-1:0]          fwd_addr_out,
   output logic [DATA_W-1:0]          fwd_data_out,
   output logic                       fwd_rdy_out,
   output logic [31:0]                stall_cnt,
   output logic [31:0]                bubble_cnt
);

   logic              valid_q, valid_d;
   logic [IR_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0] pc4_q, pc4_d;
   logic [DATA_W-1:0] ext_q, ext_d;
   logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
   logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
   logic              fwd_rdy_q, fwd_rdy_d;

   // Next value of the non-lane fields.  The write-back tag belongs to this
   // stage's own instruction, so it is never touched by the snoop bus.
   always_comb begin
      valid_d    = valid_q;
      ir_d       = ir_q;
      pc4_d      = pc4_q;
      ext_d      = ext_q;
      fwd_addr_d = fwd_addr_q;
      fwd_data_d = fwd_data_q;
      fwd_rdy_d  = fwd_rdy_q;
      if (flush) begin
         valid_d    = 1'b0;
         ir_d       = NOP_IR;
         pc4_d      = '0;
         ext_d      = '0;
         fwd_addr_d = '0;
         fwd_data_d = '0;
         fwd_rdy_d  = 1'b0;
      end else if (!stall) begin
         valid_d    = valid_in;
         ir_d       = ir_in;
         pc4_d      = pc4_in;
         ext_d      = ext_in;
         fwd_addr_d = fwd_addr_in;
         fwd_data_d = fwd_data_in;
         fwd_rdy_d  = fwd_rdy_in;
      end
   end

   // Non-lane field registers; reset drops held contents at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q    <= 1'b0;
         ir_q       <= NOP_IR;
         pc4_q      <= '0;
         ext_q      <= '0;
         fwd_addr_q <= '0;
         fwd_data_q <= '0;
         fwd_rdy_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         ir_q       <= ir_d;
         pc4_q      <= pc4_d;
         ext_q      <= ext_d;
         fwd_addr_q <= fwd_addr_d;
         fwd_data_q <= fwd_data_d;
         fwd_rdy_q  <= fwd_rdy_d;
      end
   end

   assign valid_out    = valid_q;
   assign ir_out       = ir_q;
   assign pc4_out      = pc4_q;
   assign ext_out      = ext_q;
   assign fwd_addr_out = fwd_addr_q;
   assign fwd_data_out = fwd_data_q;
   assign fwd_rdy_out  = fwd_rdy_q;

   // One independent hold/snoop slot per operand lane.
   generate
      for (genvar gi = 0; gi < NUM_OPND; gi++) begin : g_lane
         localparam int unsigned LO_D = lane_lo(gi, DATA_W);
         localparam int unsigned LO_A = lane_lo(gi, ADDR_W);
         opnd_hold_slot #(
            .DATA_W        (DATA_W),
            .ADDR_W        (ADDR_W),
            .SNOOP_ON_HOLD (SNOOP_ON_HOLD)
         ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .stall      (stall),
            .flush      (flush),
            .hold_valid (valid_q),
            .snp_we     (snp_we),
            .snp_addr   (snp_addr),
            .snp_data   (snp_data),
            .opnd_in    (opnd_in[LO_D +: DATA_W]),
            .src_in     (opnd_src_in[LO_A +: ADDR_W]),
            .opnd_out   (opnd_out[LO_D +: DATA_W]),
            .src_out    (opnd_src_out[LO_A +: ADDR_W])
         );
      end
   endgenerate

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   // Count bubbles and stalls of a live slot; both wrap naturally at 2^32.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (flush) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else if (stall && valid_q) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   assign stall_cnt  = 32'd0;
   assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a snooping instance and a
// pure-hold instance (SNOOP_ON_HOLD=0) share the same stimulus.
module tb_pipe_stage_reg;

   localparam int DW = 32;
   localparam int NO = 2;
   localparam int AW = 5;
`ifdef PIPE_STAGE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic             clk, reset, stall, flush, valid_in;
   logic [31:0]      ir_in;
   logic [DW-1:0]    pc4_in, ext_in, fwd_data_in, snp_data;
   logic [NO*DW-1:0] opnd_in;
   logic [NO*AW-1:0] opnd_src_in;
   logic [AW-1:0]    fwd_addr_in, snp_addr;
   logic             fwd_rdy_in, snp_we;

   logic             valid_out, fwd_rdy_out, valid_b, fwd_rdy_b;
   logic [31:0]      ir_out, ir_b, stall_cnt, bubble_cnt, stall_cnt_b, bubble_cnt_b;
   logic [DW-1:0]    pc4_out, ext_out, fwd_data_out, pc4_b, ext_b, fwd_data_b;
   logic [NO*DW-1:0] opnd_out, opnd_b;
   logic [NO*AW-1:0] opnd_src_out, opnd_src_b;
   logic [AW-1:0]    fwd_addr_out, fwd_addr_b;

   pipe_stage_reg #(.DATA_W(DW), .NUM_OPND(NO), .ADDR_W(AW), .SNOOP_ON_HOLD(1)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
      .ir_in(ir_in), .pc4_in(pc4_in), .ext_in(ext_in), .opnd_in(opnd_in),
      .opnd_src_in(opnd_src_in), .fwd_addr_in(fwd_addr_in), .fwd_data_in(fwd_data_in),
      .fwd_rdy_in(fwd_rdy_in), .snp_we(snp_we), .snp_addr(snp_addr), .snp_data(snp_data),
      .valid_out(valid_out), .ir_out(ir_out), .pc4_out(pc4_out), .ext_out(ext_out),
      .opnd_out(opnd_out), .opnd_src_out(opnd_src_out), .fwd_addr_out(fwd_addr_out),
      .fwd_data_out(fwd_data_out), .fwd_rdy_out(fwd_rdy_out),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_reg #(.DATA_W(DW), .NUM_OPND(NO), .ADDR_W(AW), .SNOOP_ON_HOLD(0)) dut_b (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
      .ir_in(ir_in), .pc4_in(pc4_in), .ext_in(ext_in), .opnd_in(opnd_in),
      .opnd_src_in(opnd_src_in), .fwd_addr_in(fwd_addr_in), .fwd_data_in(fwd_data_in),
      .fwd_rdy_in(fwd_rdy_in), .snp_we(snp_we), .snp_addr(snp_addr), .snp_data(snp_data),
      .valid_out(valid_b), .ir_out(ir_b), .pc4_out(pc4_b), .ext_out(ext_b),
      .opnd_out(opnd_b), .opnd_src_out(opnd_src_b), .fwd_addr_out(fwd_addr_b),
      .fwd_data_out(fwd_data_b), .fwd_rdy_out(fwd_rdy_b),
      .stall_cnt(stall_cnt_b), .bubble_cnt(bubble_cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the architectural contents of the stage register.
   logic        m_valid, m_fr;
   logic [31:0] m_ir, m_pc4, m_ext, m_fd, m_sc, m_bc;
   logic [4:0]  m_fa;
   logic [31:0] m_op[NO];
   logic [31:0] m_op_b[NO];
   logic [4:0]  m_src[NO];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_fr = 1'b0; m_ir = '0; m_pc4 = '0; m_ext = '0;
      m_fd = '0; m_fa = '0; m_sc = '0; m_bc = '0;
      for (int k = 0; k < NO; k++) begin
         m_op[k] = '0; m_op_b[k] = '0; m_src[k] = '0;
      end
   endtask

   // Effect of one rising edge with the inputs currently applied.
   task automatic model_edge();
      if (flush) begin
         m_bc = m_bc + 32'd1;
         m_valid = 1'b0; m_fr = 1'b0; m_ir = '0; m_pc4 = '0; m_ext = '0;
         m_fd = '0; m_fa = '0;
         for (int k = 0; k < NO; k++) begin
            m_op[k] = '0; m_op_b[k] = '0; m_src[k] = '0;
         end
      end else if (stall) begin
         if (m_valid) m_sc = m_sc + 32'd1;
         for (int k = 0; k < NO; k++)
            if (m_valid && snp_we && snp_addr != 5'd0 && snp_addr == m_src[k])
               m_op[k] = snp_data;
      end else begin
         m_valid = valid_in; m_ir = ir_in; m_pc4 = pc4_in; m_ext = ext_in;
         m_fa = fwd_addr_in; m_fd = fwd_data_in; m_fr = fwd_rdy_in;
         for (int k = 0; k < NO; k++) begin
            m_op[k]   = opnd_in[k*DW +: DW];
            m_op_b[k] = opnd_in[k*DW +: DW];
            m_src[k]  = opnd_src_in[k*AW +: AW];
         end
      end
   endtask

   task automatic check_all();
      chk("valid", 32'(valid_out), 32'(m_valid));
      chk("ir", ir_out, m_ir);
      chk("pc4", pc4_out, m_pc4);
      chk("ext", ext_out, m_ext);
      chk("fwd_addr", 32'(fwd_addr_out), 32'(m_fa));
      chk("fwd_data", fwd_data_out, m_fd);
      chk("fwd_rdy", 32'(fwd_rdy_out), 32'(m_fr));
      chk("stall_cnt", stall_cnt, PERF ? m_sc : 32'd0);
      chk("bubble_cnt", bubble_cnt, PERF ? m_bc : 32'd0);
      chk("b_valid", 32'(valid_b), 32'(m_valid));
      chk("b_ir", ir_b, m_ir);
      chk("b_pc4", pc4_b, m_pc4);
      chk("b_ext", ext_b, m_ext);
      chk("b_fwd_addr", 32'(fwd_addr_b), 32'(m_fa));
      chk("b_fwd_data", fwd_data_b, m_fd);
      chk("b_fwd_rdy", 32'(fwd_rdy_b), 32'(m_fr));
      chk("b_stall_cnt", stall_cnt_b, PERF ? m_sc : 32'd0);
      chk("b_bubble_cnt", bubble_cnt_b, PERF ? m_bc : 32'd0);
      for (int k = 0; k < NO; k++) begin
         chk($sformatf("opnd%0d", k), opnd_out[k*DW +: DW], m_op[k]);
         chk($sformatf("src%0d", k), 32'(opnd_src_out[k*AW +: AW]), 32'(m_src[k]));
         chk($sformatf("b_opnd%0d", k), opnd_b[k*DW +: DW], m_op_b[k]);
         chk($sformatf("b_src%0d", k), 32'(opnd_src_b[k*AW +: AW]), 32'(m_src[k]));
      end
   endtask

   // One clock edge: advance the model, then sample #1 after the edge.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
      $display("t=%0t st=%b fl=%b snp=%b/%h vld=%b ir=%h pc4=%h op=%h/%h b_op=%h/%h",
               $time, stall, flush, snp_we, snp_addr, valid_out, ir_out, pc4_out,
               opnd_out[DW-1:0], opnd_out[2*DW-1:DW], opnd_b[DW-1:0], opnd_b[2*DW-1:DW]);
   endtask

   typedef struct {
      logic st, fl, vi;
      logic [31:0] ir, pc4;
      logic [4:0]  s0, s1;
      logic [31:0] o0, o1;
      logic        we;
      logic [4:0]  sa;
      logic [31:0] sd;
      logic        e_vld;
      logic [31:0] e_ir, e_pc4, e_o0, e_o1;
   } vec_t;

   vec_t tbl[11];

   initial begin
      tbl[0]  = '{1'b0,1'b0,1'b1, 32'h1111,32'h3004, 5'd5,5'd5, 32'h11,32'h22,  1'b0,5'd0,32'h0,        1'b1, 32'h1111,32'h3004, 32'h11,32'h22};
      tbl[1]  = '{1'b1,1'b0,1'b1, 32'h2222,32'h3008, 5'd7,5'd7, 32'h33,32'h44,  1'b0,5'd0,32'h0,        1'b1, 32'h1111,32'h3004, 32'h11,32'h22};
      tbl[2]  = '{1'b1,1'b0,1'b1, 32'h2222,32'h3008, 5'd7,5'd7, 32'h33,32'h44,  1'b1,5'd5,32'hDEADBEEF, 1'b1, 32'h1111,32'h3004, 32'hDEADBEEF,32'hDEADBEEF};
      tbl[3]  = '{1'b1,1'b0,1'b1, 32'h2222,32'h3008, 5'd7,5'd7, 32'h33,32'h44,  1'b1,5'd7,32'h55,       1'b1, 32'h1111,32'h3004, 32'hDEADBEEF,32'hDEADBEEF};
      tbl[4]  = '{1'b0,1'b0,1'b1, 32'h2222,32'h3008, 5'd7,5'd7, 32'h33,32'h44,  1'b1,5'd5,32'h99,       1'b1, 32'h2222,32'h3008, 32'h33,32'h44};
      tbl[5]  = '{1'b0,1'b0,1'b1, 32'h3333,32'h300C, 5'd0,5'd3, 32'h100,32'h200,1'b0,5'd0,32'h0,        1'b1, 32'h3333,32'h300C, 32'h100,32'h200};
      tbl[6]  = '{1'b1,1'b0,1'b1, 32'h3333,32'h300C, 5'd0,5'd3, 32'h100,32'h200,1'b1,5'd0,32'hBAD,      1'b1, 32'h3333,32'h300C, 32'h100,32'h200};
      tbl[7]  = '{1'b1,1'b0,1'b1, 32'h3333,32'h300C, 5'd0,5'd3, 32'h100,32'h200,1'b1,5'd3,32'hABC,      1'b1, 32'h3333,32'h300C, 32'h100,32'hABC};
      tbl[8]  = '{1'b1,1'b1,1'b1, 32'h3333,32'h300C, 5'd0,5'd3, 32'h100,32'h200,1'b0,5'd0,32'h0,        1'b0, 32'h0,32'h0, 32'h0,32'h0};
      tbl[9]  = '{1'b0,1'b0,1'b0, 32'h4444,32'h3010, 5'd6,5'd6, 32'h1,32'h2,    1'b0,5'd0,32'h0,        1'b0, 32'h4444,32'h3010, 32'h1,32'h2};
      tbl[10] = '{1'b1,1'b0,1'b1, 32'h5555,32'h3014, 5'd6,5'd6, 32'h1,32'h2,    1'b1,5'd6,32'h77,       1'b0, 32'h4444,32'h3010, 32'h1,32'h2};

      // Power-on reset: outputs are zero before any clock edge.
      reset = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b0; ir_in = '0;
      pc4_in = '0; ext_in = '0; opnd_in = '0; opnd_src_in = '0; fwd_addr_in = '0;
      fwd_data_in = '0; fwd_rdy_in = 1'b0; snp_we = 1'b0; snp_addr = '0; snp_data = '0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;

      // First edge after reset.
      ir_in = 32'h8C01_0004; valid_in = 1'b1; pc4_in = 32'h3000;
      tick();
      chk("rst_first_ir", ir_out, 32'h8C01_0004);
      chk("rst_first_valid", 32'(valid_out), 32'd1);

      // Directed table: hold, snoop, $0 immunity, flush priority, invalid slot.
      for (int i = 0; i < 11; i++) begin
         stall = tbl[i].st; flush = tbl[i].fl; valid_in = tbl[i].vi;
         ir_in = tbl[i].ir; pc4_in = tbl[i].pc4; ext_in = tbl[i].pc4 + 32'h10;
         opnd_in = {tbl[i].o1, tbl[i].o0}; opnd_src_in = {tbl[i].s1, tbl[i].s0};
         snp_we = tbl[i].we; snp_addr = tbl[i].sa; snp_data = tbl[i].sd;
         fwd_addr_in = 5'(i); fwd_data_in = 32'h1000 + 32'(i); fwd_rdy_in = i[0];
         tick();
         chk($sformatf("row%0d_valid", i), 32'(valid_out), 32'(tbl[i].e_vld));
         chk($sformatf("row%0d_ir", i), ir_out, tbl[i].e_ir);
         chk($sformatf("row%0d_pc4", i), pc4_out, tbl[i].e_pc4);
         chk($sformatf("row%0d_op0", i), opnd_out[DW-1:0], tbl[i].e_o0);
         chk($sformatf("row%0d_op1", i), opnd_out[2*DW-1:DW], tbl[i].e_o1);
      end

      // Reset asserted mid-cycle during a stall: outputs clear without a clock.
      stall = 1'b1; flush = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("midrst_ir", ir_out, 32'h0);
      #2;
      reset = 1'b1;
      stall = 1'b0; ir_in = 32'h8C01_0004; valid_in = 1'b1;
      tick();
      chk("midrst_first_ir", ir_out, 32'h8C01_0004);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         stall = ($urandom_range(0, 9) < 4);
         flush = ($urandom_range(0, 9) == 0);
         valid_in = ($urandom_range(0, 3) != 0);
         ir_in = $urandom; pc4_in = $urandom; ext_in = $urandom;
         fwd_addr_in = 5'($urandom_range(0, 7)); fwd_data_in = $urandom;
         fwd_rdy_in = 1'($urandom_range(0, 1));
         for (int k = 0; k < NO; k++) begin
            opnd_in[k*DW +: DW] = $urandom;
            opnd_src_in[k*AW +: AW] = 5'($urandom_range(0, 7));
         end
         snp_we = 1'($urandom_range(0, 1));
         snp_addr = 5'($urandom_range(0, 7));
         snp_data = $urandom;
         tick();
      end

`ifdef PIPE_STAGE_PERF_CNT_EN
      // Stall counter wrap from a preloaded near-maximum value.
      stall = 1'b0; flush = 1'b0; valid_in = 1'b1;
      tick();
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      m_sc = 32'hFFFF_FFFE;
      stall = 1'b1; snp_we = 1'b0;
      tick();
      chk("stall_cnt_max", stall_cnt, 32'hFFFF_FFFF);
      tick();
      chk("stall_cnt_wrap", stall_cnt, 32'h0);
      stall = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
